// File: rtl/branch_pc_unit.sv
// Fetch-PC owner and EX-stage branch resolver with an HLT drain sequencer.
// Optional BRANCH_STATS_EN adds saturating taken/not-taken branch counters.
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        hlt_fetched_i,
  input  logic        br_valid_i,
  input  logic [3:0]  br_opcode_i,
  input  logic [2:0]  br_cond_i,
  input  logic [8:0]  br_imm_i,
  input  logic [15:0] br_reg_i,
  input  logic [15:0] br_pc_i,
  input  logic [2:0]  flags_i,
  output logic [15:0] pc_o,
  output logic        taken_o,
  output logic        flush_o,
  output logic        halted_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt_o,
  output logic [15:0] nottaken_cnt_o
`endif
);

  localparam logic [3:0] OP_B       = 4'hC;
  localparam logic [3:0] OP_BR      = 4'hD;
  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic        halted_q, halted_d;

  logic        z, v, n;
  logic        cond_true;
  logic        is_br;
  logic        taken;
  logic [15:0] b_off;
  logic [15:0] target;

  assign z = flags_i[2];
  assign v = flags_i[1];
  assign n = flags_i[0];

  always_comb begin
    cond_true = 1'b0;
    case (br_cond_i)
      3'b000:  cond_true = !z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = !z && !n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z || (!z && !n);
      3'b101:  cond_true = n || z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  end

  assign is_br  = br_valid_i && ((br_opcode_i == OP_B) || (br_opcode_i == OP_BR));
  assign taken  = is_br && cond_true;
  // Word offset: sign-extend the 9-bit immediate and scale to bytes.
  assign b_off  = {{6{br_imm_i[8]}}, br_imm_i, 1'b0};
  assign target = (br_opcode_i == OP_BR) ? br_reg_i : (br_pc_i + 16'd2 + b_off);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        if (taken) begin
          pc_d = target;
        end else if (!stall_i) begin
          if (hlt_fetched_i) begin
            state_d = DRAIN;
            cnt_d   = DRAIN_INIT;
          end else begin
            pc_d = pc_q + 16'd2;
          end
        end
      end
      DRAIN: begin
        // A taken branch here means the HLT was fetched on the wrong path.
        if (taken) begin
          state_d = RUN;
          pc_d    = target;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = HALTED;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      cnt_q    <= 4'd0;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign pc_o     = pc_q;
  assign taken_o  = taken;
  assign flush_o  = taken;
  assign halted_o = halted_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] tcnt_q, ntcnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tcnt_q  <= 16'd0;
      ntcnt_q <= 16'd0;
    end else if (state_q != HALTED && is_br) begin
      if (taken) begin
        if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
      end else begin
        if (ntcnt_q != 16'hFFFF) ntcnt_q <= ntcnt_q + 16'd1;
      end
    end
  end

  assign taken_cnt_o    = tcnt_q;
  assign nottaken_cnt_o = ntcnt_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: vector table, hand sequences, random run vs model.
module tb_branch_pc_unit;

  localparam logic [15:0] RPC = 16'h0000;
  localparam int          DC  = 4;

  logic        clk;
  logic        rst, stall, hlt, bv;
  logic [3:0]  bop;
  logic [2:0]  bcc, flg;
  logic [8:0]  bimm;
  logic [15:0] breg, bpc;
  logic [15:0] pc;
  logic        taken, flush, halted;
`ifdef BRANCH_STATS_EN
  logic [15:0] tcnt, ntcnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: drain expressed as "edges left before halt", -1 when running.
  logic [15:0] m_pc;
  bit          m_halt;
  int          m_drain;
  int          m_tc, m_ntc;

  branch_pc_unit #(.RESET_PC(RPC), .DRAIN_CYCLES(DC)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .hlt_fetched_i(hlt),
    .br_valid_i(bv), .br_opcode_i(bop), .br_cond_i(bcc), .br_imm_i(bimm),
    .br_reg_i(breg), .br_pc_i(bpc), .flags_i(flg),
    .pc_o(pc), .taken_o(taken), .flush_o(flush), .halted_o(halted)
`ifdef BRANCH_STATS_EN
    , .taken_cnt_o(tcnt), .nottaken_cnt_o(ntcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit cond_ref(input logic [2:0] cc, input logic [2:0] f);
    bit zz, vv, nn;
    zz = f[2]; vv = f[1]; nn = f[0];
    case (cc)
      3'd0: return !zz;
      3'd1: return zz;
      3'd2: return !zz && !nn;
      3'd3: return nn;
      3'd4: return zz || (!zz && !nn);
      3'd5: return nn || zz;
      3'd6: return vv;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit ref_taken();
    return bv && (bop == 4'hC || bop == 4'hD) && cond_ref(bcc, flg);
  endfunction

  function automatic logic [15:0] ref_target();
    int off, t;
    logic [31:0] tv;
    if (bop == 4'hD) return breg;
    off = bimm[8] ? int'(bimm) - 512 : int'(bimm);
    t   = int'(bpc) + 2 + 2 * off;
    tv  = t;
    return tv[15:0];
  endfunction

  task automatic model_step();
    bit t;
    t = ref_taken();
    if (rst) begin
      m_pc = RPC; m_halt = 0; m_drain = -1; m_tc = 0; m_ntc = 0;
    end else begin
      if (!m_halt && bv && (bop == 4'hC || bop == 4'hD)) begin
        if (t) m_tc = (m_tc < 65535) ? m_tc + 1 : m_tc;
        else   m_ntc = (m_ntc < 65535) ? m_ntc + 1 : m_ntc;
      end
      if (m_halt) begin
      end else if (m_drain >= 0) begin
        if (t) begin m_pc = ref_target(); m_drain = -1; end
        else if (m_drain == 0) m_halt = 1;
        else m_drain--;
      end else if (t) m_pc = ref_target();
      else if (stall) ;
      else if (hlt) m_drain = DC - 1;
      else m_pc = m_pc + 16'd2;
    end
  endtask

  // One clock: check combinational outputs, step model, advance, check registered outputs.
  task automatic cyc();
    bit mt;
    #1;
    mt = ref_taken();
    if (!m_halt) begin
      chk("taken", taken, mt);
      chk("flush", flush, mt);
    end
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("halted", halted, m_halt);
  endtask

  task automatic idle();
    rst = 0; stall = 0; hlt = 0; bv = 0; bop = 0; bcc = 0; flg = 0;
    bimm = 0; breg = 0; bpc = 0;
  endtask

  task automatic set_br(input logic v, input logic [3:0] op, input logic [2:0] cc,
                        input logic [2:0] f, input logic [8:0] imm,
                        input logic [15:0] p, input logic [15:0] r);
    bv = v; bop = op; bcc = cc; flg = f; bimm = imm; bpc = p; breg = r;
  endtask

  task automatic goto_pc(input logic [15:0] a);
    idle();
    set_br(1, 4'hD, 3'd7, 3'd0, 9'd0, 16'd0, a);
    cyc();
    idle();
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [2:0]  cc;
    logic [2:0]  fl;
    logic [8:0]  imm;
    logic [15:0] bpc;
    logic [15:0] rg;
    logic        exp_t;
    logic [15:0] exp_tgt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [15:0] exp_pc;
    tbl[0] = '{1, 4'hC, 3'd1, 3'b100, 9'h1FE, 16'h0010, 16'h0000, 1, 16'h000E};
    tbl[1] = '{1, 4'hC, 3'd1, 3'b000, 9'h1FE, 16'h0010, 16'h0000, 0, 16'h0000};
    tbl[2] = '{1, 4'hC, 3'd2, 3'b001, 9'h004, 16'h0010, 16'h0000, 0, 16'h0000};
    tbl[3] = '{1, 4'hD, 3'd6, 3'b010, 9'h000, 16'h0000, 16'h1235, 1, 16'h1235};
    tbl[4] = '{1, 4'hC, 3'd7, 3'b000, 9'h100, 16'h0000, 16'h0000, 1, 16'hFE02};
    tbl[5] = '{1, 4'hC, 3'd7, 3'b000, 9'h0FF, 16'h0010, 16'h0000, 1, 16'h0210};
    tbl[6] = '{1, 4'hE, 3'd7, 3'b000, 9'h004, 16'h0010, 16'h2222, 0, 16'h0000};
    tbl[7] = '{0, 4'hD, 3'd7, 3'b000, 9'h000, 16'h0000, 16'h2222, 0, 16'h0000};
    tbl[8] = '{1, 4'hC, 3'd4, 3'b100, 9'h000, 16'h0100, 16'h0000, 1, 16'h0102};
    tbl[9] = '{1, 4'hC, 3'd5, 3'b000, 9'h000, 16'h0100, 16'h0000, 0, 16'h0000};

    m_pc = 16'hxxxx; m_halt = 0; m_drain = -1; m_tc = 0; m_ntc = 0;
    idle();

    // Reset then sequential fetch
    rst = 1;
    cyc();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_halted", halted, 0);
    idle();
    cyc(); chk("seq_pc1", pc, 16'h0002);
    cyc(); chk("seq_pc2", pc, 16'h0004);
    cyc(); chk("seq_pc3", pc, 16'h0006);

    // Vector table
    foreach (tbl[i]) begin
      set_br(tbl[i].v, tbl[i].op, tbl[i].cc, tbl[i].fl, tbl[i].imm, tbl[i].bpc, tbl[i].rg);
      exp_pc = tbl[i].exp_t ? tbl[i].exp_tgt : m_pc + 16'd2;
      #1;
      chk($sformatf("vec%0d_taken", i), taken, tbl[i].exp_t);
      chk($sformatf("vec%0d_flush", i), flush, tbl[i].exp_t);
      cyc();
      chk($sformatf("vec%0d_pc", i), pc, exp_pc);
      idle();
    end

    // Condition sweep
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        set_br(1, 4'hC, 3'(c), 3'(f), 9'h000, 16'h0040, 16'h0000);
        #1;
        chk($sformatf("cc%0d_f%0d", c, f), taken, cond_ref(3'(c), 3'(f)));
        cyc();
      end
    end
    idle();

    // BR beats stall, then wrap
    set_br(1, 4'hD, 3'd7, 3'd0, 9'd0, 16'd0, 16'hFFFE);
    stall = 1;
    cyc();
    chk("br_stall_pc", pc, 16'hFFFE);
    idle();
    cyc();
    chk("wrap_pc", pc, 16'h0000);

    // Halt drain to HALTED
    goto_pc(16'h0020);
    hlt = 1;
    for (int e = 1; e <= 5; e++) begin
      cyc();
      chk($sformatf("drain_e%0d_halted", e), halted, (e == 5));
      chk($sformatf("drain_e%0d_pc", e), pc, 16'h0020);
    end
    set_br(1, 4'hD, 3'd7, 3'd0, 9'd0, 16'd0, 16'h0100);
    cyc();
    chk("halted_ignores_br_pc", pc, 16'h0020);
    chk("halted_sticky", halted, 1);
    idle(); rst = 1;
    cyc();
    chk("rst_from_halt_pc", pc, RPC);
    chk("rst_from_halt_halted", halted, 0);
    idle();

    // Wrong-path HLT: taken B on drain cycle 2
    goto_pc(16'h0020);
    hlt = 1;
    cyc(); cyc();
    set_br(1, 4'hC, 3'd7, 3'd0, 9'h007, 16'h0030, 16'h0000);
    cyc();
    chk("drain_redirect_pc", pc, 16'h0040);
    chk("drain_redirect_halted", halted, 0);
    idle();
    cyc();
    chk("after_redirect_pc", pc, 16'h0042);
    for (int k = 0; k < 6; k++) cyc();
    chk("after_redirect_halted", halted, 0);

    // Reset mid-drain
    goto_pc(16'h0020);
    hlt = 1;
    cyc(); cyc();
    rst = 1;
    cyc();
    chk("mid_drain_rst_pc", pc, RPC);
    chk("mid_drain_rst_halted", halted, 0);
    idle();
    for (int k = 0; k < 6; k++) cyc();
    chk("post_rst_halted", halted, 0);

`ifdef BRANCH_STATS_EN
    idle(); rst = 1; cyc(); idle();
    for (int k = 0; k < 3; k++) begin set_br(1, 4'hD, 3'd7, 3'd0, 9'd0, 16'd0, 16'h0080); cyc(); end
    for (int k = 0; k < 2; k++) begin set_br(1, 4'hC, 3'd1, 3'd0, 9'd0, 16'd0, 16'd0); cyc(); end
    chk("stats_taken", tcnt, 16'd3);
    chk("stats_nottaken", ntcnt, 16'd2);
    set_br(1, 4'hD, 3'd7, 3'd0, 9'd0, 16'd0, 16'h0080);
    for (int k = 0; k < 65533; k++) model_step_fast();
    cyc();
    chk("stats_sat_pre", tcnt, 16'hFFFF);
    cyc();
    chk("stats_sat", tcnt, 16'hFFFF);
    idle();
`endif

    // Randomised run against the model
    idle(); rst = 1; cyc();
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 3) == 0);
      hlt   = ($urandom_range(0, 7) == 0);
      bv    = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: bop = 4'hC;
        1: bop = 4'hD;
        default: bop = 4'($urandom);
      endcase
      bcc  = 3'($urandom);
      flg  = 3'($urandom);
      bimm = 9'($urandom);
      breg = 16'($urandom);
      bpc  = 16'($urandom);
      cyc();
`ifdef BRANCH_STATS_EN
      chk("rnd_tcnt", tcnt, m_tc[15:0]);
      chk("rnd_ntcnt", ntcnt, m_ntc[15:0]);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

`ifdef BRANCH_STATS_EN
  task automatic model_step_fast();
    model_step();
    @(posedge clk);
    #1;
  endtask
`endif

endmodule
